// File: rtl/grid_access_arbiter.sv
// -----------------------------------------------------------------------------
// grid_access_arbiter
//
// Owns the single-port 1-bit playing-grid RAM (GRID_SIZE x GRID_SIZE cells,
// 1 = wall/visited). The RAM is shared between four clients:
//   * the VGA pixel fetch (highest priority; it is never delayed),
//   * an in-flight test-and-set (TAS) write,
//   * a border/interior clear sweep,
//   * a newly accepted TAS from player 1 or player 2.
//
// Optional feature: define GRID_ARB_WAIT_CNT_EN to build the VGA stall counter
// on p_wait_cnt. When it is not defined, p_wait_cnt is tied to zero.
//
// Parameters
//   GRID_SIZE      cells per side
//   LOG_GRID_SIZE  coordinate width
//   ADDR_W         RAM address width; 2**ADDR_W must be >= GRID_SIZE*GRID_SIZE
//
// Ports
//   clk, reset_n             single clock; synchronous active-low reset
//   clear_start              pulse that requests a clear sweep
//   clear_busy / clear_done  sweep in progress / 1-cycle pulse on the last write
//   pN_req, pN_x, pN_y       player N TAS request; held until pN_gnt
//   pN_gnt, pN_hit           1-cycle completion pulse; hit is the old cell value
//   vga_req, vga_x, vga_y    pixel-fetch read request
//   vga_valid, vga_bit       read result, one cycle after vga_req
//   ram_addr, ram_we,        RAM port; ram_addr = y*GRID_SIZE + x
//   ram_wdata, ram_rdata     (ram_rdata is registered, so it has 1-cycle latency)
//   p_wait_cnt               saturating count of TAS cycles stalled by VGA
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module grid_access_arbiter #(
  parameter int unsigned GRID_SIZE     = 50,
  parameter int unsigned LOG_GRID_SIZE = 6,
  parameter int unsigned ADDR_W        = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  // Clear sweep control
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done,
  // Player 1 TAS port
  input  logic                     p1_req,
  input  logic [LOG_GRID_SIZE-1:0] p1_x,
  input  logic [LOG_GRID_SIZE-1:0] p1_y,
  output logic                     p1_gnt,
  output logic                     p1_hit,
  // Player 2 TAS port
  input  logic                     p2_req,
  input  logic [LOG_GRID_SIZE-1:0] p2_x,
  input  logic [LOG_GRID_SIZE-1:0] p2_y,
  output logic                     p2_gnt,
  output logic                     p2_hit,
  // VGA read port
  input  logic                     vga_req,
  input  logic [LOG_GRID_SIZE-1:0] vga_x,
  input  logic [LOG_GRID_SIZE-1:0] vga_y,
  output logic                     vga_valid,
  output logic                     vga_bit,
  // Grid RAM port
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic                     ram_wdata,
  input  logic                     ram_rdata,
  // Statistics
  output logic [15:0]              p_wait_cnt
);

  localparam int unsigned             NumCells  = GRID_SIZE * GRID_SIZE;
  localparam logic [ADDR_W-1:0]        LastAddr  = ADDR_W'(NumCells - 1);
  localparam logic [LOG_GRID_SIZE-1:0] LastCoord = LOG_GRID_SIZE'(GRID_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StTasRd,
    StTasWr,
    StTasRsp
  } state_e;

  // Linear cell address. Only used for in-range coordinates, so the product
  // always fits in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [LOG_GRID_SIZE-1:0] x,
                                                  input logic [LOG_GRID_SIZE-1:0] y);
    return (ADDR_W'(y) * ADDR_W'(GRID_SIZE)) + ADDR_W'(x);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                     state_q;
  logic                       tas_sel_q;      // 0: player 1, 1: player 2
  logic [ADDR_W-1:0]          tas_addr_q;
  logic                       tas_first_q;    // first TAS_WR cycle: ram_rdata holds our read
  logic                       tas_old_q;
  logic                       rr_last_q;      // 0: P1 served last, 1: P2 served last
  logic                       clr_pend_q;
  logic [ADDR_W-1:0]          clr_addr_q;
  logic [LOG_GRID_SIZE-1:0]   clr_x_q;
  logic [LOG_GRID_SIZE-1:0]   clr_y_q;
  logic                       clear_busy_q;
  logic                       p1_gnt_q, p1_hit_q;
  logic                       p2_gnt_q, p2_hit_q;
  logic                       vga_valid_q;
  logic                       vga_in_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                     vga_in;
  logic                     vga_access;
  logic                     pick_p2;
  logic [LOG_GRID_SIZE-1:0] pick_x;
  logic [LOG_GRID_SIZE-1:0] pick_y;
  logic                     pick_in;
  logic                     clr_wr;
  logic                     clr_last;
  logic                     clr_wdata;
  logic                     tas_rd;
  logic                     tas_wr;
  logic                     tas_old_now;

  always_comb begin
    vga_in     = (vga_x <= LastCoord) && (vga_y <= LastCoord);
    vga_access = vga_req && vga_in;

    // Round robin: P1 wins unless P2 is requesting and P1 was served last.
    pick_p2 = p2_req && (!p1_req || !rr_last_q);
    pick_x  = pick_p2 ? p2_x : p1_x;
    pick_y  = pick_p2 ? p2_y : p1_y;
    pick_in = (pick_x <= LastCoord) && (pick_y <= LastCoord);

    // Any vga_req, even out of range, holds off clear and TAS for that cycle.
    // reset_n gates every RAM write so an abort takes effect in the same cycle.
    clr_wr    = reset_n && (state_q == StClear) && !vga_req;
    clr_last  = (clr_addr_q == LastAddr);
    clr_wdata = (clr_x_q == '0) || (clr_x_q == LastCoord) ||
                (clr_y_q == '0) || (clr_y_q == LastCoord);
    tas_rd    = reset_n && (state_q == StTasRd) && !vga_req;
    tas_wr    = reset_n && (state_q == StTasWr) && !vga_req;

    // If the write was stalled, the read data has since been replaced by VGA
    // traffic, so use the copy captured on the first TAS_WR cycle.
    tas_old_now = tas_first_q ? ram_rdata : tas_old_q;
  end

  // ---------------------------------------------------------------------------
  // RAM port mux: VGA > TAS read/write > clear
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 1'b0;
    if (vga_access) begin
      ram_addr = cell_addr(vga_x, vga_y);
    end else if (tas_rd || tas_wr) begin
      ram_addr  = tas_addr_q;
      ram_we    = tas_wr;
      ram_wdata = tas_wr;
    end else if (clr_wr) begin
      ram_addr  = clr_addr_q;
      ram_we    = 1'b1;
      ram_wdata = clr_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tas_sel_q    <= 1'b0;
      tas_addr_q   <= '0;
      tas_first_q  <= 1'b0;
      tas_old_q    <= 1'b0;
      rr_last_q    <= 1'b1;
      clr_pend_q   <= 1'b0;
      clr_addr_q   <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      clear_busy_q <= 1'b0;
      p1_gnt_q     <= 1'b0;
      p1_hit_q     <= 1'b0;
      p2_gnt_q     <= 1'b0;
      p2_hit_q     <= 1'b0;
      vga_valid_q  <= 1'b0;
      vga_in_q     <= 1'b0;
    end else begin
      p1_gnt_q    <= 1'b0;
      p1_hit_q    <= 1'b0;
      p2_gnt_q    <= 1'b0;
      p2_hit_q    <= 1'b0;
      vga_valid_q <= vga_req;
      vga_in_q    <= vga_in;

      // A clear requested while a TAS owns the grid runs once the TAS is done.
      if (clear_start && (state_q inside {StTasRd, StTasWr, StTasRsp})) begin
        clr_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (clear_start || clr_pend_q) begin
            state_q      <= StClear;
            clr_pend_q   <= 1'b0;
            clear_busy_q <= 1'b1;
            clr_addr_q   <= '0;
            clr_x_q      <= '0;
            clr_y_q      <= '0;
          end else if (p1_req || p2_req) begin
            tas_sel_q  <= pick_p2;
            tas_addr_q <= cell_addr(pick_x, pick_y);
            if (pick_in) begin
              state_q <= StTasRd;
            end else begin
              // Off-grid cells read as walls and are never written.
              state_q <= StTasRsp;
              if (pick_p2) begin
                p2_gnt_q <= 1'b1;
                p2_hit_q <= 1'b1;
              end else begin
                p1_gnt_q <= 1'b1;
                p1_hit_q <= 1'b1;
              end
            end
          end
        end

        StClear: begin
          if (!vga_req) begin
            if (clr_last) begin
              state_q      <= StIdle;
              clear_busy_q <= 1'b0;
            end else begin
              clr_addr_q <= clr_addr_q + ADDR_W'(1);
              if (clr_x_q == LastCoord) begin
                clr_x_q <= '0;
                clr_y_q <= clr_y_q + LOG_GRID_SIZE'(1);
              end else begin
                clr_x_q <= clr_x_q + LOG_GRID_SIZE'(1);
              end
            end
          end
        end

        StTasRd: begin
          if (!vga_req) begin
            state_q     <= StTasWr;
            tas_first_q <= 1'b1;
          end
        end

        StTasWr: begin
          if (tas_first_q) begin
            tas_old_q   <= ram_rdata;
            tas_first_q <= 1'b0;
          end
          if (!vga_req) begin
            state_q <= StTasRsp;
            if (tas_sel_q) begin
              p2_gnt_q <= 1'b1;
              p2_hit_q <= tas_old_now;
            end else begin
              p1_gnt_q <= 1'b1;
              p1_hit_q <= tas_old_now;
            end
          end
        end

        StTasRsp: begin
          rr_last_q <= tas_sel_q;
          state_q   <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional VGA stall counter
  // ---------------------------------------------------------------------------
`ifdef GRID_ARB_WAIT_CNT_EN
  logic [15:0] wait_cnt_q;
  logic        tas_stall;

  assign tas_stall = vga_req && ((state_q == StTasRd) || (state_q == StTasWr));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (clear_start) begin
      wait_cnt_q <= '0;
    end else if (tas_stall && (wait_cnt_q != 16'hFFFF)) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign p_wait_cnt = wait_cnt_q;
`else
  assign p_wait_cnt = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign clear_busy = clear_busy_q;
  assign clear_done = clr_wr && clr_last;
  assign p1_gnt     = p1_gnt_q;
  assign p1_hit     = p1_hit_q;
  assign p2_gnt     = p2_gnt_q;
  assign p2_hit     = p2_hit_q;
  assign vga_valid  = vga_valid_q;
  // Off-grid reads return 0 without touching the RAM.
  assign vga_bit    = vga_valid_q && vga_in_q && ram_rdata;

endmodule

// File: tb/tb_grid_access_arbiter.sv
`timescale 1ns/1ps

module tb_grid_access_arbiter;

  localparam int GS = 50;
  localparam int LG = 6;
  localparam int AW = 12;

`ifdef GRID_ARB_WAIT_CNT_EN
  localparam int WaitExp = 10;
`else
  localparam int WaitExp = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear_start;
  logic          clear_busy;
  logic          clear_done;
  logic          p1_req;
  logic [LG-1:0] p1_x;
  logic [LG-1:0] p1_y;
  logic          p1_gnt;
  logic          p1_hit;
  logic          p2_req;
  logic [LG-1:0] p2_x;
  logic [LG-1:0] p2_y;
  logic          p2_gnt;
  logic          p2_hit;
  logic          vga_req;
  logic [LG-1:0] vga_x;
  logic [LG-1:0] vga_y;
  logic          vga_valid;
  logic          vga_bit;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_wdata;
  logic          ram_rdata;
  logic [15:0]   p_wait_cnt;

  always #5 clk = ~clk;

  grid_access_arbiter #(
    .GRID_SIZE    (GS),
    .LOG_GRID_SIZE(LG),
    .ADDR_W       (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .p1_req     (p1_req),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p1_gnt     (p1_gnt),
    .p1_hit     (p1_hit),
    .p2_req     (p2_req),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .p2_gnt     (p2_gnt),
    .p2_hit     (p2_hit),
    .vga_req    (vga_req),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_valid  (vga_valid),
    .vga_bit    (vga_bit),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .p_wait_cnt (p_wait_cnt)
  );

  // Single-port grid RAM with registered read data.
  logic mem [4096];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int we_seen = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t q_vga[$];
  exp_t q_p1[$];
  exp_t q_p2[$];
  exp_t q_done[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(input string name, input int act, input bit empty, input exp_t e);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected output %0d at cycle %0d", name, act, cyc);
    end else begin
      check({name, "_val"}, act, e.val);
      check({name, "_cycle"}, cyc, e.cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    bit   empty;
    if (clear_busy) busy_cnt++;
    if (ram_we) we_seen++;
    if (vga_valid) begin
      e = '{0, 0};
      empty = (q_vga.size() == 0);
      if (!empty) e = q_vga.pop_front();
      score("vga", int'(vga_bit), empty, e);
    end
    if (p1_gnt) begin
      e = '{0, 0};
      empty = (q_p1.size() == 0);
      if (!empty) e = q_p1.pop_front();
      score("p1_hit", int'(p1_hit), empty, e);
    end
    if (p2_gnt) begin
      e = '{0, 0};
      empty = (q_p2.size() == 0);
      if (!empty) e = q_p2.pop_front();
      score("p2_hit", int'(p2_hit), empty, e);
    end
    if (clear_done) begin
      e = '{0, 0};
      empty = (q_done.size() == 0);
      if (!empty) e = q_done.pop_front();
      score("clear_done", 1, empty, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vga_read(input int x, input int y, input int exp);
    vga_x   = LG'(x);
    vga_y   = LG'(y);
    vga_req = 1'b1;
    q_vga.push_back('{exp, cyc + 1});
    tick();
    vga_req = 1'b0;
  endtask

  // Issues a TAS and waits (bounded) for its grant; lat is cycles from acceptance.
  task automatic tas(input int p, input int x, input int y, input int hit, input int lat);
    bit got = 1'b0;
    if (p == 1) begin
      p1_x = LG'(x); p1_y = LG'(y); p1_req = 1'b1;
      q_p1.push_back('{hit, cyc + lat});
    end else begin
      p2_x = LG'(x); p2_y = LG'(y); p2_req = 1'b1;
      q_p2.push_back('{hit, cyc + lat});
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if ((p == 1 && p1_gnt) || (p == 2 && p2_gnt)) begin
        got = 1'b1;
        break;
      end
    end
    p1_req = 1'b0;
    p2_req = 1'b0;
    check("tas_gnt_seen", int'(got), 1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ones;
    bit got;

    reset_n = 1'b0; clear_start = 1'b0;
    p1_req = 1'b0; p1_x = '0; p1_y = '0;
    p2_req = 1'b0; p2_x = '0; p2_y = '0;
    vga_req = 1'b0; vga_x = '0; vga_y = '0;
    repeat (3) tick();

    // Reset state
    check("rst_clear_busy", int'(clear_busy), 0);
    check("rst_clear_done", int'(clear_done), 0);
    check("rst_p1_gnt", int'(p1_gnt), 0);
    check("rst_p2_gnt", int'(p2_gnt), 0);
    check("rst_vga_valid", int'(vga_valid), 0);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_wait_cnt", int'(p_wait_cnt), 0);
    reset_n = 1'b1;
    tick();

    // 1. Full clear sweep
    busy_cnt = 0;
    clear_start = 1'b1;
    q_done.push_back('{1, cyc + GS * GS});
    tick();
    clear_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (clear_done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("clear_done_seen", int'(got), 1);
    tick();
    check("clear_busy_after", int'(clear_busy), 0);
    check("clear_busy_cycles", busy_cnt, GS * GS);
    ones = 0;
    for (int a = 0; a < GS * GS; a++) ones += int'(mem[a]);
    check("clear_border_cells", ones, 4 * GS - 4);
    vga_read(0, 7, 1);
    vga_read(49, 3, 1);
    vga_read(10, 25, 0);
    vga_read(25, 49, 1);
    vga_read(48, 48, 0);
    check("wait_cnt_idle", int'(p_wait_cnt), 0);

    // 2. Single-player TAS, repeat, readback; then one P2 TAS so P2 is last served
    tas(1, 12, 25, 0, 3);
    tas(1, 12, 25, 1, 3);
    vga_read(12, 25, 1);
    tas(2, 30, 30, 0, 3);

    // 3. Simultaneous requests to the same cell
    k = cyc;
    p1_x = 6'd20; p1_y = 6'd20; p1_req = 1'b1;
    p2_x = 6'd20; p2_y = 6'd20; p2_req = 1'b1;
    q_p1.push_back('{0, k + 3});
    q_p2.push_back('{1, k + 7});
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (p1_gnt) p1_req = 1'b0;
      if (p2_gnt) begin
        got = 1'b1;
        break;
      end
    end
    p1_req = 1'b0;
    p2_req = 1'b0;
    check("both_p2_gnt_seen", int'(got), 1);
    tick();

    // 4. VGA holds the port for 10 cycles while P2's TAS waits
    k = cyc;
    p2_x = 6'd5; p2_y = 6'd5; p2_req = 1'b1;
    q_p2.push_back('{0, k + 13});
    tick();
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      vga_x = LG'(i);
      vga_y = '0;
      vga_req = 1'b1;
      q_vga.push_back('{1, cyc + 1});
      tick();
    end
    vga_req = 1'b0;
    check("stall_no_write", we_seen, 0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (p2_gnt) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    p2_req = 1'b0;
    check("stall_p2_gnt_seen", int'(got), 1);
    tick();
    check("stall_wait_cnt", int'(p_wait_cnt), WaitExp);
    vga_read(5, 5, 1);

    // 5. clear_start during TAS_WR is deferred; then reset aborts the sweep
    k = cyc;
    p1_x = 6'd7; p1_y = 6'd7; p1_req = 1'b1;
    q_p1.push_back('{0, k + 3});
    tick();
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    p1_req = 1'b0;
    check("pend_busy_at_gnt", int'(clear_busy), 0);
    check("pend_wait_cleared", int'(p_wait_cnt), 0);
    tick();
    check("pend_busy_idle", int'(clear_busy), 0);
    tick();
    check("pend_busy_start", int'(clear_busy), 1);
    repeat (15) tick();
    reset_n = 1'b0;
    tick();
    check("abort_busy", int'(clear_busy), 0);
    check("abort_done", int'(clear_done), 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("abort_busy_after", int'(clear_busy), 0);

    // 6. Off-grid TAS and VGA read
    we_seen = 0;
    tas(1, 50, 10, 1, 1);
    check("oob_tas_no_write", we_seen, 0);
    vga_read(63, 0, 0);
    vga_read(12, 25, 1);
    repeat (3) tick();

    check("q_vga_empty", q_vga.size(), 0);
    check("q_p1_empty", q_p1.size(), 0);
    check("q_p2_empty", q_p2.size(), 0);
    check("q_done_empty", q_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
